// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: multiply/divide opcodes, FSM states and iteration count.
package mips_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'b00,
      MD_CALC = 2'b01,
      MD_FIX  = 2'b10
   } md_state_e;

   localparam int MD_ITER = 32;

endpackage

// File: rtl/mul_div_core.sv
// One combinational iteration of the shift-add multiply or the restoring divide.
module mul_div_core #(
   parameter int W = 32
) (
   input  logic           is_div,
   input  logic [2*W-1:0] acc,
   input  logic [W-1:0]   opnd,
   output logic [2*W-1:0] acc_next
);

   logic [W:0] sum;
   logic [W:0] trial;

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      sum      = {1'b0, acc[2*W-1:W]} + {1'b0, opnd};
      trial    = acc[2*W-1:W-1] - {1'b0, opnd};
      acc_next = acc;
      if (is_div) begin
         // trial uses the 33-bit shifted remainder; its MSB is the borrow
         if (!trial[W]) acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
         else           acc_next = {acc[2*W-2:0], 1'b0};
      end else if (acc[0]) begin
         acc_next = {sum, acc[W-1:1]};
      end else begin
         acc_next = {1'b0, acc[2*W-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS multiply/divide unit: 32 iterations on magnitudes, signs fixed up at the end.
module mul_div_unit
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [1:0]       MDOp,
   input  logic             Start,
   input  logic             HiWrite,
   input  logic             LoWrite,
   input  logic [WIDTH-1:0] WriteData,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam int CW = $clog2(MD_ITER);
   localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

   md_state_e          state_q, state_n;
   md_op_e             op_q;
   logic [CW-1:0]      cnt_q;
   logic [WIDTH-1:0]   opnd_q;
   logic [2*WIDTH-1:0] acc_q, acc_next;
   logic               neg_res_q, neg_rem_q, div_zero_q;
   logic [WIDTH-1:0]   hi_q, lo_q;
   logic               done_q;

   logic               is_signed, neg_a, neg_b, is_div_in, is_div;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

   always_comb begin
      is_signed = ~MDOp[0];
      is_div_in = MDOp[1];
      neg_a     = is_signed & SrcA[WIDTH-1];
      neg_b     = is_signed & SrcB[WIDTH-1];
      mag_a     = neg_a ? -SrcA : SrcA;
      mag_b     = neg_b ? -SrcB : SrcB;
   end

   assign is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);

   mul_div_core #(.W(WIDTH)) u_core (
      .is_div   (is_div),
      .acc      (acc_q),
      .opnd     (opnd_q),
      .acc_next (acc_next)
   );

   // Remainder magnitude is the raw dividend on divide-by-zero, so re-signing it restores SrcA.
   always_comb begin
      prod   = neg_res_q ? -acc_q : acc_q;
      quo    = div_zero_q ? '1 : (neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
      rem    = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
      fix_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
      fix_lo = is_div ? quo : prod[WIDTH-1:0];
   end

   always_comb begin
      state_n = state_q;
      unique case (state_q)
         MD_IDLE: if (Start) state_n = MD_CALC;
         MD_CALC: if (cnt_q == LAST) state_n = MD_FIX;
         MD_FIX:  state_n = MD_IDLE;
         default: state_n = MD_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= MD_IDLE;
      else      state_q <= state_n;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         op_q       <= MD_MULT;
         cnt_q      <= '0;
         opnd_q     <= '0;
         acc_q      <= '0;
         neg_res_q  <= 1'b0;
         neg_rem_q  <= 1'b0;
         div_zero_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= (state_q == MD_FIX);
         unique case (state_q)
            MD_IDLE: begin
               if (HiWrite) hi_q <= WriteData;
               if (LoWrite) lo_q <= WriteData;
               if (Start) begin
                  op_q       <= md_op_e'(MDOp);
                  cnt_q      <= '0;
                  opnd_q     <= is_div_in ? mag_b : mag_a;
                  acc_q      <= {{WIDTH{1'b0}}, (is_div_in ? mag_a : mag_b)};
                  neg_res_q  <= neg_a ^ neg_b;
                  neg_rem_q  <= neg_a;
                  div_zero_q <= (SrcB == '0);
               end
            end
            MD_CALC: begin
               acc_q <= acc_next;
               cnt_q <= cnt_q + 1'b1;
            end
            MD_FIX: begin
               hi_q <= fix_hi;
               lo_q <= fix_lo;
            end
            default: ;
         endcase
      end
   end

   assign Busy = (state_q != MD_IDLE);
   assign Done = done_q;
   assign Hi   = hi_q;
   assign Lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

   logic        CLK, RST;
   logic [31:0] SrcA, SrcB, WriteData;
   logic [1:0]  MDOp;
   logic        Start, HiWrite, LoWrite;
   logic        Busy, Done;
   logic [31:0] Hi, Lo;

   int n_checks = 0;
   int n_pass   = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .CLK(CLK), .RST(RST), .SrcA(SrcA), .SrcB(SrcB), .MDOp(MDOp),
      .Start(Start), .HiWrite(HiWrite), .LoWrite(LoWrite), .WriteData(WriteData),
      .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Reference: returns {HI, LO} computed with plain integer arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      int              ia, ib, q, r;
      case (op)
         2'b00: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
         end
         2'b01: begin
            ua = a;
            ub = b;
            return ua * ub;
         end
         2'b10: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
            ia = $signed(a);
            ib = $signed(b);
            q  = ia / ib;
            r  = ia % ib;
            return {32'(r), 32'(q)};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   task automatic wait_done(output int cyc, output int busy_cyc);
      cyc = 0;
      busy_cyc = 0;
      while (!Done && cyc < 40) begin
         if (Busy) busy_cyc++;
         @(posedge CLK); #1;
         cyc++;
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
      logic [63:0] exp;
      int cyc, busy_cyc;
      exp = model(op, a, b);
      @(negedge CLK);
      MDOp = op; SrcA = a; SrcB = b; Start = 1'b1;
      @(posedge CLK); #1;
      Start = 1'b0; SrcA = $urandom; SrcB = $urandom; MDOp = 2'($urandom);
      wait_done(cyc, busy_cyc);
      if (cyc !== 33) $display("FAIL %s latency: got %0d want 33", name, cyc); else n_pass++;
      n_checks++;
      if (busy_cyc !== 33) $display("FAIL %s busy_cycles: got %0d want 33", name, busy_cyc); else n_pass++;
      n_checks++;
      if (Busy !== 1'b0) $display("FAIL %s busy_at_done: got %b want 0", name, Busy); else n_pass++;
      n_checks++;
      if (Hi !== exp[63:32]) $display("FAIL %s hi: got %h want %h (op=%0d a=%h b=%h)", name, Hi, exp[63:32], op, a, b); else n_pass++;
      n_checks++;
      if (Lo !== exp[31:0]) $display("FAIL %s lo: got %h want %h (op=%0d a=%h b=%h)", name, Lo, exp[31:0], op, a, b); else n_pass++;
      n_checks++;
      @(posedge CLK); #1;
      if (Done !== 1'b0) $display("FAIL %s done_pulse: got %b want 0", name, Done); else n_pass++;
      n_checks++;
   endtask

   task automatic test_reset();
      RST = 1'b0; Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      SrcA = '0; SrcB = '0; MDOp = '0; WriteData = '0;
      repeat (2) @(posedge CLK);
      #1;
      if ({Busy, Done, Hi, Lo} !== 66'b0) $display("FAIL reset_state: got busy=%b done=%b hi=%h lo=%h want all 0", Busy, Done, Hi, Lo); else n_pass++;
      n_checks++;
      @(negedge CLK); RST = 1'b1;
   endtask

   task automatic test_directed();
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      if (Hi !== 32'hFFFF_FFFE || Lo !== 32'h0000_0001) $display("FAIL multu_max_const: got %h_%h want fffffffe_00000001", Hi, Lo); else n_pass++;
      n_checks++;
      run_op(2'b00, 32'hFFFF_FFFD, 32'd7, "mult_neg");
      if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFEB) $display("FAIL mult_neg_const: got %h_%h want ffffffff_ffffffeb", Hi, Lo); else n_pass++;
      n_checks++;
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_neg");
      if (Hi !== 32'hFFFF_FFFF || Lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_const: got %h_%h want ffffffff_fffffffd", Hi, Lo); else n_pass++;
      n_checks++;
      run_op(2'b11, 32'd100, 32'd7, "divu");
      run_op(2'b11, 32'd5, 32'd0, "divu_zero");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "div_neg_divisor");
      run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minmin");
   endtask

   task automatic test_random();
      logic [31:0] corner [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      logic [31:0] a, b;
      for (int i = 0; i < 30; i++) begin
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
         if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
         run_op(2'($urandom_range(0, 3)), a, b, "random");
      end
   endtask

   task automatic test_busy_ignore();
      int cyc, busy_cyc;
      @(negedge CLK);
      MDOp = 2'b11; SrcA = 32'd100; SrcB = 32'd7; Start = 1'b1;
      @(posedge CLK); #1;
      Start = 1'b0;
      repeat (4) @(posedge CLK);
      #1;
      Start = 1'b1; MDOp = 2'b01; SrcA = 32'h1111_1111; SrcB = 32'h3;
      HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hDEAD_BEEF;
      repeat (3) @(posedge CLK);
      #1;
      Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
      if (Hi === 32'hDEAD_BEEF || Lo === 32'hDEAD_BEEF) $display("FAIL busy_mthi: got hi=%h lo=%h want not deadbeef", Hi, Lo); else n_pass++;
      n_checks++;
      wait_done(cyc, busy_cyc);
      if (cyc !== 26) $display("FAIL busy_ignore_latency: got %0d want 26", cyc); else n_pass++;
      n_checks++;
      if (Hi !== 32'd2 || Lo !== 32'd14) $display("FAIL busy_ignore_result: got %h_%h want 00000002_0000000e", Hi, Lo); else n_pass++;
      n_checks++;
      @(posedge CLK); #1;
      if (Busy !== 1'b0) $display("FAIL busy_start_queued: got busy=%b want 0", Busy); else n_pass++;
      n_checks++;
      @(negedge CLK); LoWrite = 1'b1; WriteData = 32'h1234_5678;
      @(posedge CLK); #1; LoWrite = 1'b0;
      if (Lo !== 32'h1234_5678 || Hi !== 32'd2) $display("FAIL mtlo: got hi=%h lo=%h want 00000002_12345678", Hi, Lo); else n_pass++;
      n_checks++;
      @(negedge CLK); HiWrite = 1'b1; WriteData = 32'h0BAD_F00D;
      @(posedge CLK); #1; HiWrite = 1'b0;
      if (Hi !== 32'h0BAD_F00D || Lo !== 32'h1234_5678) $display("FAIL mthi: got hi=%h lo=%h want 0badf00d_12345678", Hi, Lo); else n_pass++;
      n_checks++;
      @(negedge CLK);
      MDOp = 2'b01; SrcA = 32'd6; SrcB = 32'd7; Start = 1'b1; LoWrite = 1'b1; WriteData = 32'hAAAA_5555;
      @(posedge CLK); #1; Start = 1'b0; LoWrite = 1'b0;
      if (Lo !== 32'hAAAA_5555 || Busy !== 1'b1) $display("FAIL start_with_mtlo: got lo=%h busy=%b want aaaa5555 1", Lo, Busy); else n_pass++;
      n_checks++;
      wait_done(cyc, busy_cyc);
      if (Lo !== 32'd42 || Hi !== 32'd0) $display("FAIL start_with_mtlo_result: got %h_%h want 00000000_0000002a", Hi, Lo); else n_pass++;
      n_checks++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp2;
      int cyc, busy_cyc;
      exp2 = model(2'b10, 32'hFFFF_FF9C, 32'd9);
      @(negedge CLK);
      MDOp = 2'b01; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1;
      @(posedge CLK); #1;
      MDOp = 2'b10; SrcA = 32'hFFFF_FF9C; SrcB = 32'd9;
      wait_done(cyc, busy_cyc);
      if (cyc !== 33 || Busy !== 1'b0) $display("FAIL b2b_first: got cyc=%0d busy=%b want 33 0", cyc, Busy); else n_pass++;
      n_checks++;
      if (Lo !== 32'd15) $display("FAIL b2b_first_result: got %h want 0000000f", Lo); else n_pass++;
      n_checks++;
      @(posedge CLK); #1;
      Start = 1'b0;
      if (Busy !== 1'b1) $display("FAIL b2b_accept_e34: got busy=%b want 1", Busy); else n_pass++;
      n_checks++;
      wait_done(cyc, busy_cyc);
      if (cyc !== 33) $display("FAIL b2b_second_latency: got %0d want 33", cyc); else n_pass++;
      n_checks++;
      if ({Hi, Lo} !== exp2) $display("FAIL b2b_second_result: got %h_%h want %h", Hi, Lo, exp2); else n_pass++;
      n_checks++;
   endtask

   task automatic test_reset_mid();
      @(negedge CLK); HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hCAFE_F00D;
      @(posedge CLK); #1; HiWrite = 1'b0; LoWrite = 1'b0;
      @(negedge CLK); MDOp = 2'b01; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF; Start = 1'b1;
      @(posedge CLK); #1; Start = 1'b0;
      repeat (10) @(posedge CLK);
      #2;
      if (Busy !== 1'b1) $display("FAIL reset_mid_busy_before: got %b want 1", Busy); else n_pass++;
      n_checks++;
      RST = 1'b0;
      #1;
      if ({Busy, Done, Hi, Lo} !== 66'b0) $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h want all 0", Busy, Done, Hi, Lo); else n_pass++;
      n_checks++;
      repeat (2) @(posedge CLK);
      @(negedge CLK); RST = 1'b1;
      @(posedge CLK); #1;
      if (Busy !== 1'b0 || Hi !== 32'd0) $display("FAIL reset_mid_after_release: got busy=%b hi=%h want 0 0", Busy, Hi); else n_pass++;
      n_checks++;
      run_op(2'b01, 32'd6, 32'd7, "post_reset_multu");
      if (Lo !== 32'd42 || Hi !== 32'd0) $display("FAIL post_reset_const: got %h_%h want 00000000_0000002a", Hi, Lo); else n_pass++;
      n_checks++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_busy_ignore();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
